// File: rtl/bakraid_eeprom_93c66.sv
// 93C66 (x16) Microwire EEPROM responder: command decode, 256x16 RAM, write-enable latch, busy/ready status.
// Optional host NVRAM port on the RAM's second port when BAKRAID_EEPROM_HOSTPORT_EN is defined.
module bakraid_eeprom_93c66 #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int BUSY_CYCLES = 480
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SCLK,
  input  logic          SCS,
  input  logic          SDI,
  output logic          SDO,
  output logic          BUSY
`ifdef BAKRAID_EEPROM_HOSTPORT_EN
  ,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_DIN,
  input  logic          HOST_WE,
  output logic [DW-1:0] HOST_DOUT
`endif
);

  localparam int CW           = AW + 2;
  localparam int WORDS        = 1 << AW;
  localparam int SWEEP_CYCLES = (BUSY_CYCLES > WORDS) ? BUSY_CYCLES : WORDS;
  localparam int CNTW         = $clog2(((CW > DW) ? CW : DW) + 1);
  localparam int BITW         = $clog2(DW);
  localparam int BCW          = $clog2(SWEEP_CYCLES + 1);
  localparam int WLW          = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_RD     = 3'd2,
    S_WR     = 3'd3,
    S_PROG   = 3'd4,
    S_STATUS = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_sclk_s;
  logic [1:0]      r_scs_s;
  logic [1:0]      r_sdi_s;
  logic            r_sclk_d;
  logic            r_sdo;
  logic            r_busy;
  logic            w_sdo_nxt;
  logic            w_busy_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CW-2:0]   r_sr;
  logic            r_pend;
  logic            r_ewe;
  logic            r_all;
  logic [AW-1:0]   r_addr;
  logic [BITW-1:0] r_bit;
  logic [DW-1:0]   r_wdata;
  logic [AW-1:0]   r_waddr;
  logic [WLW-1:0]  r_wleft;
  logic [BCW-1:0]  r_busy_cnt;
  logic [DW-1:0]   r_ram_q;
  logic [DW-1:0]   r_mem [WORDS];

  logic            w_rise;
  logic            w_scs;
  logic            w_sdi;
  logic [CW-1:0]   w_cmd;
  logic [1:0]      w_op;
  logic [1:0]      w_sub;
  logic            w_cmd_end;
  logic            w_commit;
  logic            w_host_we;
  logic            w_stall;
  logic            w_prog_wr;
  logic            w_last;

  assign w_rise    = r_sclk_s[1] & ~r_sclk_d;
  assign w_scs     = r_scs_s[1];
  assign w_sdi     = r_sdi_s[1];
  assign w_cmd     = {r_sr, w_sdi};
  assign w_op      = w_cmd[CW-1:CW-2];
  assign w_sub     = w_cmd[AW-1:AW-2];
  assign w_cmd_end = (r_state == S_CMD) && w_scs && w_rise && (r_cnt == CNTW'(CW - 1));
  assign w_commit  = ((r_state == S_CMD && r_pend) || (r_state == S_WR && r_cnt == CNTW'(DW)))
                     && !w_scs && r_ewe;
`ifdef BAKRAID_EEPROM_HOSTPORT_EN
  assign w_host_we = HOST_WE;
`else
  assign w_host_we = 1'b0;
`endif
  // A host write in the same cycle holds the serial write and the busy count for one CLK.
  assign w_stall   = (r_state == S_PROG) && (r_wleft != '0) && w_host_we;
  assign w_prog_wr = (r_state == S_PROG) && (r_wleft != '0) && !w_host_we;
  assign w_last    = (r_state == S_PROG) && (r_busy_cnt == BCW'(1)) && !w_stall;

  assign SDO  = r_sdo;
  assign BUSY = r_busy;

  // Two-flop synchronisers for the CPU-side serial pins plus SCLK edge history.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sclk_s <= 2'b00;
      r_scs_s  <= 2'b00;
      r_sdi_s  <= 2'b00;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], SCLK};
      r_scs_s  <= {r_scs_s[0], SCS};
      r_sdi_s  <= {r_sdi_s[0], SDI};
      r_sclk_d <= r_sclk_s[1];
    end
  end

  // State register with registered SDO/BUSY.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_sdo   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sdo   <= w_sdo_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise && w_scs && w_sdi) w_state_nxt = S_CMD;
        else                          w_state_nxt = S_IDLE;
      end
      S_CMD: begin
        if (!w_scs) begin
          w_state_nxt = w_commit ? S_PROG : S_IDLE;
        end else if (w_cmd_end) begin
          case (w_op)
            2'b10:   w_state_nxt = S_RD;
            2'b01:   w_state_nxt = S_WR;
            2'b00:   w_state_nxt = (w_sub == 2'b01) ? S_WR : S_CMD;
            default: w_state_nxt = S_CMD;
          endcase
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_RD: begin
        if (!w_scs) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_RD;
      end
      S_WR: begin
        if (!w_scs) w_state_nxt = w_commit ? S_PROG : S_IDLE;
        else        w_state_nxt = S_WR;
      end
      S_PROG: begin
        if (w_last) w_state_nxt = S_STATUS;
        else        w_state_nxt = S_PROG;
      end
      S_STATUS: begin
        if (!w_scs) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_STATUS;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next SDO/BUSY values; SDO carries the dummy bit, read data or ready status.
  always_comb begin
    w_sdo_nxt  = 1'b1;
    w_busy_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sdo_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
      end
      S_CMD: begin
        w_busy_nxt = w_commit;
        if (w_cmd_end && w_op == 2'b10) w_sdo_nxt = 1'b0;
        else                            w_sdo_nxt = 1'b1;
      end
      S_RD: begin
        w_busy_nxt = 1'b0;
        if (!w_scs)      w_sdo_nxt = 1'b1;
        else if (w_rise) w_sdo_nxt = r_ram_q[r_bit];
        else             w_sdo_nxt = r_sdo;
      end
      S_WR: begin
        w_busy_nxt = w_commit;
        w_sdo_nxt  = 1'b1;
      end
      S_PROG: begin
        w_busy_nxt = !w_last;
        w_sdo_nxt  = w_last ? 1'b1 : !w_scs;
      end
      S_STATUS: begin
        w_busy_nxt = 1'b0;
        w_sdo_nxt  = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_sdo_nxt  = 1'b1;
      end
    endcase
  end

  // Command/data shifting, write-enable latch, read pointer and program sequencing.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cnt      <= '0;
      r_sr       <= '0;
      r_pend     <= 1'b0;
      r_ewe      <= 1'b0;
      r_all      <= 1'b0;
      r_addr     <= '0;
      r_bit      <= '0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_wleft    <= '0;
      r_busy_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_pend <= 1'b0;
        end
        S_CMD: begin
          if (w_scs && w_rise && r_cnt < CNTW'(CW)) begin
            r_sr  <= w_cmd[CW-2:0];
            r_cnt <= r_cnt + CNTW'(1);
            if (r_cnt == CNTW'(CW - 1)) begin
              r_addr <= w_cmd[AW-1:0];
              r_bit  <= BITW'(DW - 1);
              case (w_op)
                2'b01: begin
                  r_all <= 1'b0;
                  r_cnt <= '0;
                end
                2'b11: begin
                  r_all   <= 1'b0;
                  r_wdata <= '1;
                  r_pend  <= 1'b1;
                end
                2'b00: begin
                  case (w_sub)
                    2'b01: begin
                      r_all <= 1'b1;
                      r_cnt <= '0;
                    end
                    2'b10: begin
                      r_all   <= 1'b1;
                      r_wdata <= '1;
                      r_pend  <= 1'b1;
                    end
                    2'b11:   r_ewe <= 1'b1;
                    default: r_ewe <= 1'b0;
                  endcase
                end
                default: r_all <= 1'b0;
              endcase
            end
          end
        end
        S_WR: begin
          if (w_scs && w_rise && r_cnt < CNTW'(DW)) begin
            r_wdata <= {r_wdata[DW-2:0], w_sdi};
            r_cnt   <= r_cnt + CNTW'(1);
          end
        end
        S_RD: begin
          if (w_scs && w_rise) begin
            if (r_bit == '0) begin
              r_bit  <= BITW'(DW - 1);
              r_addr <= r_addr + AW'(1);
            end else begin
              r_bit <= r_bit - BITW'(1);
            end
          end
        end
        S_PROG: begin
          if (!w_stall) begin
            r_busy_cnt <= r_busy_cnt - BCW'(1);
            if (r_wleft != '0) begin
              r_waddr <= r_waddr + AW'(1);
              r_wleft <= r_wleft - WLW'(1);
            end
          end
        end
        default: r_cnt <= '0;
      endcase
      if (w_commit) begin
        r_waddr    <= r_all ? '0 : r_addr;
        r_wleft    <= r_all ? WLW'(WORDS) : WLW'(1);
        r_busy_cnt <= r_all ? BCW'(SWEEP_CYCLES) : BCW'(BUSY_CYCLES);
      end
    end
  end

  // RAM holds the complement of each word so a zero-initialised array reads back as erased (all ones).
  always_ff @(posedge CLK) begin
`ifdef BAKRAID_EEPROM_HOSTPORT_EN
    if (HOST_WE)        r_mem[HOST_ADDR] <= ~HOST_DIN;
    else if (w_prog_wr) r_mem[r_waddr]   <= ~r_wdata;
`else
    if (w_prog_wr) r_mem[r_waddr] <= ~r_wdata;
`endif
  end

  // Serial-side read port, refreshed every cycle from the read pointer.
  always_ff @(posedge CLK) begin
    r_ram_q <= ~r_mem[r_addr];
  end

`ifdef BAKRAID_EEPROM_HOSTPORT_EN
  logic [DW-1:0] r_host_q;

  // Host read port, one CLK behind HOST_ADDR.
  always_ff @(posedge CLK) begin
    r_host_q <= ~r_mem[HOST_ADDR];
  end

  assign HOST_DOUT = r_host_q;
`endif

endmodule

// File: tb/tb_bakraid_eeprom_93c66.sv
// Directed bench for the 93C66 responder: reads, protected writes, aborts, sequential read, sweeps, reset.
module tb_bakraid_eeprom_93c66;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic SCLK  = 1'b0;
  logic SCS   = 1'b0;
  logic SDI   = 1'b0;
  logic SDO;
  logic BUSY;
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [9:0] C_EWEN = 10'b0011000000;
  localparam logic [9:0] C_EWDS = 10'b0000000000;
  localparam logic [9:0] C_WRAL = 10'b0001000000;
  localparam logic [9:0] C_ERAL = 10'b0010000000;

`ifdef BAKRAID_EEPROM_HOSTPORT_EN
  logic [7:0]  host_addr = 8'h00;
  logic [15:0] host_din  = 16'h0000;
  logic        host_we   = 1'b0;
  logic [15:0] host_dout;
`endif

  bakraid_eeprom_93c66 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SCLK      (SCLK),
    .SCS       (SCS),
    .SDI       (SDI),
    .SDO       (SDO),
    .BUSY      (BUSY)
`ifdef BAKRAID_EEPROM_HOSTPORT_EN
    ,
    .HOST_ADDR (host_addr),
    .HOST_DIN  (host_din),
    .HOST_WE   (host_we),
    .HOST_DOUT (host_dout)
`endif
  );

  always #10 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One serial bit: SDI set, SCLK high 4 CLK later, SDO sampled 4 CLK after the rise.
  task automatic send_bit(input logic b, output logic so);
    SDI  = b;
    clks(4);
    SCLK = 1'b1;
    clks(4);
    so   = SDO;
    SCLK = 1'b0;
  endtask

  // Leading zero, start bit, then the 10-bit opcode+address; so is SDO after the last bit.
  task automatic send_cmd(input logic [9:0] c, output logic so);
    logic d;
    SCS = 1'b1;
    clks(2);
    send_bit(1'b0, d);
    send_bit(1'b1, d);
    for (int i = 9; i >= 0; i--) send_bit(c[i], so);
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    logic d;
    for (int i = 15; i > 15 - nbits; i--) send_bit(w[i], d);
  endtask

  task automatic recv(input int nbits, output logic [31:0] v);
    logic d;
    v = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(1'b0, d);
      v = {v[30:0], d};
    end
  endtask

  task automatic cs_low();
    SCS = 1'b0;
    SDI = 1'b0;
    clks(4);
  endtask

  // Drop SCS and measure the BUSY pulse (bounded).
  task automatic commit(output int len, output bit seen);
    SCS  = 1'b0;
    SDI  = 1'b0;
    seen = 1'b0;
    len  = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      clks(1);
      if (BUSY === 1'b1) seen = 1'b1;
    end
    while (BUSY === 1'b1 && len < 2000) begin
      len++;
      clks(1);
    end
    clks(4);
  endtask

  task automatic read_word(input logic [7:0] a, output logic dmy, output logic [15:0] w);
    logic [31:0] v;
    send_cmd({2'b10, a}, dmy);
    recv(16, v);
    w = v[15:0];
    cs_low();
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] w, output int len, output bit seen);
    logic d;
    send_cmd(C_EWEN, d);
    cs_low();
    send_cmd({2'b01, a}, d);
    send_word(w, 16);
    commit(len, seen);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    clks(3);
    n_total++;
    if (SDO !== 1'b1) $display("FAIL reset_sdo got %b want 1", SDO); else n_pass++;
    n_total++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
    RESET = 1'b1;
    clks(2);
  endtask

  task automatic test_read_erased();
    logic        dmy;
    logic [15:0] w;
    read_word(8'h05, dmy, w);
    n_total++;
    if (dmy !== 1'b0) $display("FAIL rd05_dummy got %b want 0", dmy); else n_pass++;
    n_total++;
    if (w !== 16'hFFFF) $display("FAIL rd05_erased got %h want ffff", w); else n_pass++;
    n_total++;
    if (SDO !== 1'b1) $display("FAIL rd05_sdo_idle got %b want 1", SDO); else n_pass++;
  endtask

  task automatic test_write_busy();
    logic        d;
    logic [15:0] w;
    int          len;
    bit          seen;
    send_cmd(C_EWEN, d);
    cs_low();
    send_cmd({2'b01, 8'h05}, d);
    send_word(16'h1234, 16);
    SCS  = 1'b0;
    SDI  = 1'b0;
    seen = 1'b0;
    len  = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      clks(1);
      if (BUSY === 1'b1) seen = 1'b1;
    end
    while (BUSY === 1'b1 && len < 2000) begin
      len++;
      if (len == 100) SCS = 1'b1;
      if (len == 110) begin
        n_total++;
        if (SDO !== 1'b0) $display("FAIL wr_busy_sdo got %b want 0", SDO); else n_pass++;
        SCS = 1'b0;
      end
      if (len == 120) begin
        n_total++;
        if (SDO !== 1'b1) $display("FAIL wr_busy_sdo_cs_low got %b want 1", SDO); else n_pass++;
      end
      clks(1);
    end
    n_total++;
    if (!seen) $display("FAIL wr_busy_seen got 0 want 1"); else n_pass++;
    n_total++;
    if (len != 480) $display("FAIL wr_busy_len got %0d want 480", len); else n_pass++;
    clks(4);
    n_total++;
    if (SDO !== 1'b1) $display("FAIL wr_ready_sdo got %b want 1", SDO); else n_pass++;
    read_word(8'h05, d, w);
    n_total++;
    if (w !== 16'h1234) $display("FAIL wr_readback got %h want 1234", w); else n_pass++;
  endtask

  task automatic test_ewds();
    logic        d;
    logic [15:0] w;
    int          len;
    bit          seen;
    send_cmd(C_EWDS, d);
    cs_low();
    send_cmd({2'b01, 8'h06}, d);
    send_word(16'hABCD, 16);
    commit(len, seen);
    n_total++;
    if (seen) $display("FAIL ewds_busy got 1 want 0"); else n_pass++;
    read_word(8'h06, d, w);
    n_total++;
    if (w !== 16'hFFFF) $display("FAIL ewds_readback got %h want ffff", w); else n_pass++;
  endtask

  task automatic test_abort();
    logic        d;
    logic [15:0] w;
    int          len;
    bit          seen;
    send_cmd(C_EWEN, d);
    cs_low();
    send_cmd({2'b01, 8'h07}, d);
    send_word(16'h1357, 9);
    commit(len, seen);
    n_total++;
    if (seen) $display("FAIL abort_busy got 1 want 0"); else n_pass++;
    read_word(8'h07, d, w);
    n_total++;
    if (w !== 16'hFFFF) $display("FAIL abort_readback got %h want ffff", w); else n_pass++;
  endtask

  task automatic test_seq_read();
    logic        d;
    logic [31:0] v;
    logic [31:0] e;
    int          len;
    bit          seen;
    e = 32'hBEEF0F0F;
    write_word(8'hFF, 16'hBEEF, len, seen);
    write_word(8'h00, 16'h0F0F, len, seen);
    send_cmd({2'b10, 8'hFF}, d);
    n_total++;
    if (d !== 1'b0) $display("FAIL seq_dummy got %b want 0", d); else n_pass++;
    SDI  = 1'b0;
    clks(4);
    SCLK = 1'b1;
    clks(2);
    n_total++;
    if (SDO !== 1'b0) $display("FAIL seq_latency_early got %b want 0", SDO); else n_pass++;
    clks(1);
    n_total++;
    if (SDO !== 1'b1) $display("FAIL seq_latency_3clk got %b want 1", SDO); else n_pass++;
    clks(1);
    SCLK = 1'b0;
    recv(31, v);
    cs_low();
    n_total++;
    if (v[30:0] !== e[30:0]) $display("FAIL seq_wrap got %h want %h", v[30:0], e[30:0]); else n_pass++;
  endtask

  task automatic test_sweeps();
    logic        d;
    logic [15:0] w;
    logic [7:0]  addrs [3];
    int          len;
    bit          seen;
    addrs[0] = 8'h00;
    addrs[1] = 8'h80;
    addrs[2] = 8'hFF;
    send_cmd(C_EWEN, d);
    cs_low();
    send_cmd(C_WRAL, d);
    send_word(16'h5A5A, 16);
    commit(len, seen);
    n_total++;
    if (len != 480) $display("FAIL wral_busy_len got %0d want 480", len); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      read_word(addrs[i], d, w);
      n_total++;
      if (w !== 16'h5A5A) $display("FAIL wral_rd_%h got %h want 5a5a", addrs[i], w); else n_pass++;
    end
    send_cmd(C_ERAL, d);
    commit(len, seen);
    n_total++;
    if (len != 480) $display("FAIL eral_busy_len got %0d want 480", len); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      read_word(addrs[i], d, w);
      n_total++;
      if (w !== 16'hFFFF) $display("FAIL eral_rd_%h got %h want ffff", addrs[i], w); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic        d;
    logic [15:0] w;
    int          len;
    bit          seen;
    send_cmd(C_WRAL, d);
    send_word(16'h1111, 16);
    SCS  = 1'b0;
    SDI  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      clks(1);
      if (BUSY === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL sweep_busy_seen got 0 want 1"); else n_pass++;
    clks(100);
    RESET = 1'b0;
    clks(1);
    n_total++;
    if (BUSY !== 1'b0) $display("FAIL sweep_reset_busy got %b want 0", BUSY); else n_pass++;
    n_total++;
    if (SDO !== 1'b1) $display("FAIL sweep_reset_sdo got %b want 1", SDO); else n_pass++;
    RESET = 1'b1;
    clks(2);
    read_word(8'h00, d, w);
    n_total++;
    if (w !== 16'h1111) $display("FAIL sweep_kept_00 got %h want 1111", w); else n_pass++;
    read_word(8'h50, d, w);
    n_total++;
    if (w !== 16'h1111) $display("FAIL sweep_kept_50 got %h want 1111", w); else n_pass++;
    read_word(8'hFF, d, w);
    n_total++;
    if (w !== 16'hFFFF) $display("FAIL sweep_unwritten_ff got %h want ffff", w); else n_pass++;
    send_cmd({2'b01, 8'h10}, d);
    send_word(16'h2222, 16);
    commit(len, seen);
    n_total++;
    if (seen) $display("FAIL reset_clears_ewe busy got 1 want 0"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_erased();
    test_write_busy();
    test_ewds();
    test_abort();
    test_seq_read();
    test_sweeps();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
